// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package inst_fetch_pkg;

    localparam int xlen = 32;

    // Instruction handed to the decoder while nothing has been fetched yet.
    localparam logic [xlen-1:0] nop_inst = 32'h0000_0013;

    // Sequential fetch increment (one 32-bit word).
    localparam logic [xlen-1:0] pc_step = 32'd4;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [xlen-1:0] inst;
        logic [xlen-1:0] pc;
    } fetch_bundle_t;

    // Request side of the instruction memory port.
    typedef struct packed {
        logic            req;
        logic [xlen-1:0] addr;
    } mem_req_t;

    // Clears the byte offset so every fetch address is word aligned.
    function automatic logic [xlen-1:0] word_align(input logic [xlen-1:0] addr);
        return {addr[xlen-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Small fetch buffer holding {inst, pc} bundles. Depth must be a power of
// two so the read/write pointers wrap on their own.
module inst_fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int depth = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_bundle_t            push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(depth):0]   count,
    output fetch_bundle_t            head
);

    localparam int              aw      = $clog2(depth);
    localparam logic [aw:0]     depth_c = (aw + 1)'(depth);
    localparam logic [aw:0]     cnt_one = (aw + 1)'(1);

    fetch_bundle_t   store [depth];
    logic [aw-1:0]   rd_ptr;
    logic [aw-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == depth_c);
    assign do_pop  = pop && !empty;
    // A full buffer can still take a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = store[rd_ptr];

    // Storage, pointers and occupancy; flush empties the buffer on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) begin
                store[i] <= '{inst: nop_inst, pc: '0};
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                store[wr_ptr] <= push_data;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + cnt_one;
                2'b01:   count <= count - cnt_one;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues sequential in-order fetches, buffers the
// returned words with their PC and presents them to the decoder. Branch
// redirects kill in-flight fetches and pulse the decoder flush.
//
// Handshake (decoder side): valid/inst/cur_pc only change after a transfer
// (valid && ready at a rising edge), a redirect, or reset; while valid=1 and
// ready=0 the word is held stable. Memory side: mem_req/mem_addr stay put
// until mem_gnt is seen with mem_req=1; responses arrive in request order.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [xlen-1:0] reset_pc   = '0,
    parameter int              fifo_depth = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic [xlen-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [xlen-1:0] mem_rdata,
    input  logic            redirect,
    input  logic [xlen-1:0] redirect_pc,
    output logic            valid,
    input  logic            ready,
    output logic [xlen-1:0] inst,
    output logic [xlen-1:0] cur_pc,
    output logic            flush_pipe,
    output logic            misalign
);

    localparam int            cw       = $clog2(fifo_depth) + 1;
    localparam logic [cw:0]   depth_cu = (cw + 1)'(fifo_depth);

    logic [xlen-1:0] fetch_pc;
    logic [xlen-1:0] resp_pc;
    logic [cw-1:0]   outstanding;
    logic [cw-1:0]   outstanding_next;
    logic [cw-1:0]   discard;
    logic [cw:0]     in_use;

    logic            fifo_full;
    logic            fifo_empty;
    logic [cw-1:0]   fifo_count;
    fetch_bundle_t   fifo_head;
    fetch_bundle_t   push_bundle;
    logic            fifo_push;
    logic            pop;
    logic            grant;
    mem_req_t        req_bus;

    // Head transfer to the decoder; a redirect flushes instead of popping.
    assign pop = !fifo_empty && ready && !redirect;

    // Slots already claimed by in-flight fetches and buffered words. The word
    // leaving this cycle frees its slot early so a 1-cycle memory streams at
    // one instruction per cycle with only two entries.
    assign in_use = {1'b0, outstanding} + {1'b0, fifo_count} - {{cw{1'b0}}, pop};

    assign req_bus.req  = !rst && !redirect && (in_use < depth_cu);
    assign req_bus.addr = fetch_pc;
    assign mem_req      = req_bus.req;
    assign mem_addr     = req_bus.addr;
    assign grant        = req_bus.req && mem_gnt;

    assign outstanding_next = outstanding + {{(cw-1){1'b0}}, grant}
                                          - {{(cw-1){1'b0}}, mem_rvalid};

    // Responses still owed to a killed fetch stream are dropped, never buffered.
    assign fifo_push   = mem_rvalid && !redirect && (discard == '0);
    assign push_bundle = '{inst: mem_rdata, pc: resp_pc};

    inst_fetch_fifo #(
        .depth (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_bundle),
        .pop       (pop),
        .flush     (redirect),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign valid  = !fifo_empty;
    assign inst   = fifo_head.inst;
    assign cur_pc = fifo_head.pc;

    // PC tracking, in-flight accounting and the one-cycle redirect pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= reset_pc;
            resp_pc     <= reset_pc;
            outstanding <= '0;
            discard     <= '0;
            flush_pipe  <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            flush_pipe  <= redirect;
            misalign    <= redirect && (redirect_pc[1:0] != 2'b00);
            outstanding <= outstanding_next;
            if (redirect) begin
                // Every fetch still in flight belongs to the old stream.
                fetch_pc <= word_align(redirect_pc);
                resp_pc  <= word_align(redirect_pc);
                discard  <= outstanding_next;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + pc_step;
                end
                if (mem_rvalid) begin
                    if (discard != '0) begin
                        discard <= discard - {{(cw-1){1'b0}}, 1'b1};
                    end else begin
                        resp_pc <= resp_pc + pc_step;
                    end
                end
            end
        end
    end

    // The credit scheme must keep the buffer from ever overflowing.
    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && fifo_full && !pop));

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios followed by a
// randomized run, checked against a PC-stream reference model.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int depth = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid;
    logic        ready;
    logic [31:0] inst;
    logic [31:0] cur_pc;
    logic        flush_pipe;
    logic        misalign;

    inst_fetch #(
        .reset_pc   (32'h0000_0000),
        .fifo_depth (depth)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .valid       (valid),
        .ready       (ready),
        .inst        (inst),
        .cur_pc      (cur_pc),
        .flush_pipe  (flush_pipe),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Memory model: in-order responses after a per-request random latency.
    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mreq_t;
    mreq_t       memq[$];
    int unsigned cyc     = 0;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    int unsigned gnt_pct = 100;
    logic [31:0] xor_key = 32'h0;

    // Reference model: next address the fetch stream should ask for, and the
    // PC of the next instruction the decoder should see.
    logic [31:0] exp_fetch = 32'h0;
    logic [31:0] exp_pc    = 32'h0;
    logic        prev_redirect = 1'b0;
    logic        prev_mis      = 1'b0;
    logic        prev_hold     = 1'b0;
    logic [31:0] prev_pc       = 32'h0;

    // Statistics for the directed scenarios.
    int grants, valid_cnt, delivered, flush_cnt, mis_cnt;
    int first_grant, first_valid;
    logic        last_valid, last_rvalid;
    logic [31:0] last_pc;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ xor_key;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        grants = 0; valid_cnt = 0; delivered = 0; flush_cnt = 0; mis_cnt = 0;
        first_grant = -1; first_valid = -1;
    endtask

    // One clock cycle. Entered at a negedge with ready/redirect/redirect_pc
    // already driven; leaves at the following negedge.
    task automatic tick();
        logic        g;
        logic        p;
        logic        rv;
        logic [31:0] a;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = word_of(memq[0].addr);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        mem_gnt = ($urandom_range(99) < gnt_pct);
        #1;
        if (prev_redirect) begin
            check("flush_pulse", {31'b0, flush_pipe}, 32'd1);
            check("misalign_pulse", {31'b0, misalign}, {31'b0, prev_mis});
            check("valid_after_redirect", {31'b0, valid}, 32'd0);
        end else begin
            check("flush_idle", {31'b0, flush_pipe}, 32'd0);
            check("misalign_idle", {31'b0, misalign}, 32'd0);
        end
        if (redirect) check("req_during_redirect", {31'b0, mem_req}, 32'd0);
        else if (memq.size() == 0 && !valid) check("req_when_idle", {31'b0, mem_req}, 32'd1);
        if (mem_req) check("fetch_addr", mem_addr, exp_fetch);
        if (prev_hold) begin
            check("hold_valid", {31'b0, valid}, 32'd1);
            check("hold_pc", cur_pc, prev_pc);
        end
        if (valid) begin
            check("head_pc", cur_pc, exp_pc);
            check("head_inst", inst, word_of(exp_pc));
        end

        g  = mem_req && mem_gnt;
        p  = valid && ready && !redirect;
        rv = mem_rvalid;
        a  = mem_addr;
        if (g) begin
            grants++;
            if (first_grant < 0) first_grant = int'(cyc);
        end
        if (valid) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = int'(cyc);
        end
        if (p) delivered++;
        if (flush_pipe) flush_cnt++;
        if (misalign) mis_cnt++;
        last_valid  = valid;
        last_pc     = cur_pc;
        last_rvalid = mem_rvalid;

        prev_hold     = valid && !ready && !redirect;
        prev_pc       = cur_pc;
        prev_redirect = redirect;
        prev_mis      = redirect && (redirect_pc[1:0] != 2'b00);
        if (redirect) begin
            exp_fetch = {redirect_pc[31:2], 2'b00};
            exp_pc    = {redirect_pc[31:2], 2'b00};
        end else begin
            if (g) exp_fetch = exp_fetch + 32'd4;
            if (p) exp_pc    = exp_pc + 32'd4;
        end

        @(posedge clk);
        if (rv) void'(memq.pop_front());
        if (g) memq.push_back('{addr: a, due: cyc + $urandom_range(lat_max, lat_min)});
        cyc++;
        check("inflight_bound", {31'b0, (memq.size() <= depth)}, 32'd1);
        @(negedge clk);
    endtask

    // Runs cycles until the decoder sees a valid word, bounded.
    task automatic wait_valid(input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (last_valid) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        tick();
        redirect    = 1'b0;
        redirect_pc = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
        check({tag, "_valid"}, {31'b0, valid}, 32'd0);
        check({tag, "_inst"}, inst, 32'h0000_0013);
        check({tag, "_cur_pc"}, cur_pc, 32'd0);
        check({tag, "_flush"}, {31'b0, flush_pipe}, 32'd0);
        check({tag, "_misalign"}, {31'b0, misalign}, 32'd0);
    endtask

    initial begin
        logic found;
        rst         = 1'b1;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        ready       = 1'b0;
        clear_stats();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // 1: 1-cycle memory, word = addr, decoder always ready.
        ready = 1'b1;
        repeat (12) tick();
        check("t1_first_latency", 32'(first_valid - first_grant), 32'd2);
        check("t1_consecutive_valid", 32'(valid_cnt), 32'd10);
        check("t1_delivered", 32'(delivered), 32'd10);

        // 6: asynchronous reset mid-stream with a fetch in flight.
        check("t6_inflight_before", 32'(memq.size()), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        memq.delete();
        exp_fetch     = 32'h0;
        exp_pc        = 32'h0;
        prev_redirect = 1'b0;
        prev_hold     = 1'b0;
        xor_key       = 32'hA5A5_0000;
        @(negedge clk);
        rst = 1'b0;
        clear_stats();

        // 2: decoder stalls after the first valid; credits cap the requests.
        ready = 1'b0;
        repeat (7) tick();
        check("t2_grants_capped", 32'(grants), 32'd2);
        check("t2_first_grant_cycle_ok", {31'b0, first_grant >= 0}, 32'd1);
        clear_stats();
        ready = 1'b1;
        repeat (3) tick();
        check("t2_release_valid", 32'(valid_cnt), 32'd3);
        check("t2_release_delivered", 32'(delivered), 32'd3);

        // 3: 3-cycle memory, two fetches in flight, then redirect to 0x100.
        lat_min = 3;
        lat_max = 3;
        found   = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = (memq.size() == 2);
        end
        check("t3_two_inflight", {31'b0, found}, 32'd1);
        clear_stats();
        do_redirect(32'h0000_0100);
        wait_valid(20, found);
        check("t3_restart_valid", {31'b0, found}, 32'd1);
        check("t3_restart_pc", last_pc, 32'h0000_0100);
        check("t3_flush_once", 32'(flush_cnt), 32'd1);

        // 4: misaligned redirect target.
        clear_stats();
        do_redirect(32'h0000_0103);
        wait_valid(20, found);
        check("t4_restart_valid", {31'b0, found}, 32'd1);
        check("t4_restart_pc", last_pc, 32'h0000_0100);
        check("t4_misalign_once", 32'(mis_cnt), 32'd1);

        // 5: redirect coinciding with a response and a decoder pop.
        lat_min = 1;
        lat_max = 1;
        repeat (6) tick();
        do_redirect(32'h0000_0040);
        check("t5_rvalid_same_cycle", {31'b0, last_rvalid}, 32'd1);
        check("t5_valid_same_cycle", {31'b0, last_valid}, 32'd1);
        wait_valid(20, found);
        check("t5_restart_valid", {31'b0, found}, 32'd1);
        check("t5_restart_pc", last_pc, 32'h0000_0040);

        // Randomized traffic: grants, latency, stalls and redirects.
        lat_min = 1;
        lat_max = 4;
        gnt_pct = 70;
        clear_stats();
        for (int i = 0; i < 1500; i++) begin
            ready = ($urandom_range(99) < 75);
            if ($urandom_range(99) < 4) begin
                redirect    = 1'b1;
                redirect_pc = $urandom;
            end else begin
                redirect    = 1'b0;
                redirect_pc = $urandom;
            end
            tick();
        end
        redirect = 1'b0;
        check("rand_progress", {31'b0, delivered > 100}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
